// File: rtl/nn_input_framer_if.sv
// Pixel-stream and network-side signals of the input framer.
// The master drives pixels and NNoutValid; the slave (the framer) returns the frame.
interface nn_input_framer_if #(
  parameter int dataWidth = 8,
  parameter int numInputs = 784
);
  logic [7:0]                      pixIn;
  logic                            pixValid;
  logic                            pixSof;
  logic                            pixReady;
  logic [numInputs*dataWidth-1:0]  NNin;
  logic                            NNvalid;
  logic                            NNoutValid;
  logic [9:0]                      pixCount;
  logic                            frameErr;
  logic [15:0]                     frameCount;

  modport master (
    output pixIn, pixValid, pixSof, NNoutValid,
    input  pixReady, NNin, NNvalid, pixCount, frameErr, frameCount
  );

  modport slave (
    input  pixIn, pixValid, pixSof, NNoutValid,
    output pixReady, NNin, NNvalid, pixCount, frameErr, frameCount
  );
endinterface

// File: rtl/nn_input_framer.sv
// Packs a serial pixel stream into the flattened NNin frame and holds it
// stable (NNvalid) until the network signals NNoutValid.
module nn_input_framer #(
  parameter int dataWidth   = 8,
  parameter int numInputs   = 784,
  parameter int PIXEL_SHIFT = 1
) (
  input  logic             clk,
  input  logic             reset,
  nn_input_framer_if.slave bus
);
  localparam int IW = $clog2(numInputs*dataWidth);

  typedef enum logic {FILL, HOLD} state_t;

  state_t                         state_q;
  logic [numInputs*dataWidth-1:0] NNin_q;
  logic                           NNvalid_q, pixReady_q, frameErr_q;
  logic [9:0]                     pixCount_q;
  logic [15:0]                    frameCount_q;

  logic [7:0]           pix_shift_d;
  logic [dataWidth-1:0] elem_d;
  logic                 accept_d, restart_d;
  logic [9:0]           wr_idx_d;
  logic [IW-1:0]        wr_base_d;

  // An early pixSof rewinds to element 0; the first pixel lands in the MSB element.
  always_comb begin
    pix_shift_d = bus.pixIn >> PIXEL_SHIFT;
    elem_d      = dataWidth'(pix_shift_d);
    accept_d    = (state_q == FILL) && bus.pixValid && pixReady_q;
    restart_d   = bus.pixSof && (pixCount_q != '0);
    wr_idx_d    = restart_d ? '0 : pixCount_q;
    wr_base_d   = IW'((numInputs - 1 - int'(wr_idx_d)) * dataWidth);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= FILL;
      NNin_q       <= '0;
      NNvalid_q    <= 1'b0;
      pixReady_q   <= 1'b1;
      pixCount_q   <= '0;
      frameErr_q   <= 1'b0;
      frameCount_q <= '0;
    end else begin
      frameErr_q <= 1'b0;
      case (state_q)
        FILL: begin
          if (accept_d) begin
            NNin_q[wr_base_d +: dataWidth] <= elem_d;
            if (restart_d) begin
              frameErr_q <= 1'b1;
              pixCount_q <= 10'd1;
            end else if (pixCount_q == 10'(numInputs - 1)) begin
              state_q      <= HOLD;
              pixCount_q   <= 10'(numInputs);
              pixReady_q   <= 1'b0;
              NNvalid_q    <= 1'b1;
              frameCount_q <= frameCount_q + 16'd1;
            end else begin
              pixCount_q <= pixCount_q + 10'd1;
            end
          end
        end
        HOLD: begin
          if (bus.NNoutValid) begin
            state_q    <= FILL;
            pixCount_q <= '0;
            NNvalid_q  <= 1'b0;
            pixReady_q <= 1'b1;
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

  assign bus.NNin       = NNin_q;
  assign bus.NNvalid    = NNvalid_q;
  assign bus.pixReady   = pixReady_q;
  assign bus.pixCount   = pixCount_q;
  assign bus.frameErr   = frameErr_q;
  assign bus.frameCount = frameCount_q;
endmodule

// File: tb/tb_nn_input_framer.sv
// Directed bench for nn_input_framer: element table checks plus hand-written
// sequences for restart, gaps, reset and back-to-back frames.
module tb_nn_input_framer;
  localparam int DW = 8;
  localparam int NI = 784;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  nn_input_framer_if #(.dataWidth(DW), .numInputs(NI)) bus ();

  nn_input_framer #(.dataWidth(DW), .numInputs(NI), .PIXEL_SHIFT(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    int         k;
    logic [7:0] elem;
  } elem_vec_t;

  int checks = 0;
  int errors = 0;
  logic [NI*DW-1:0] exp_vec;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic chk_frame(input string name);
    int bad = 0;
    for (int k = 0; k < NI; k++)
      if (bus.NNin[(NI-1-k)*DW +: DW] !== exp_vec[(NI-1-k)*DW +: DW]) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s mismatched_elements=%0d required=0", name, bad);
    end
  endtask

  // Drive inputs just after an edge, let one edge sample them, then settle.
  task automatic step(input logic v, input logic [7:0] p, input logic s, input logic ov);
    bus.pixValid   = v;
    bus.pixIn      = p;
    bus.pixSof     = s;
    bus.NNoutValid = ov;
    @(posedge clk);
    #1;
  endtask

  function automatic void set_exp(input int k, input logic [7:0] p);
    exp_vec[(NI-1-k)*DW +: DW] = p >> 1;
  endfunction

  task automatic chk_reset_state(input string tag);
    chk({tag, " pixReady"},   32'(bus.pixReady),   32'd1);
    chk({tag, " NNvalid"},    32'(bus.NNvalid),    32'd0);
    chk({tag, " pixCount"},   32'(bus.pixCount),   32'd0);
    chk({tag, " frameErr"},   32'(bus.frameErr),   32'd0);
    chk({tag, " frameCount"}, 32'(bus.frameCount), 32'd0);
    chk({tag, " NNin zero"},  32'(bus.NNin == '0), 32'd1);
  endtask

  initial begin
    elem_vec_t tbl[8];
    logic [7:0] p;
    tbl[0] = '{0,   8'h00};
    tbl[1] = '{1,   8'h00};
    tbl[2] = '{3,   8'h01};
    tbl[3] = '{200, 8'h64};
    tbl[4] = '{254, 8'h7F};
    tbl[5] = '{255, 8'h7F};
    tbl[6] = '{256, 8'h00};
    tbl[7] = '{783, 8'h07};

    reset = 1'b1;
    exp_vec = '0;
    step(0, 8'h00, 0, 0);
    step(0, 8'h00, 0, 0);
    reset = 1'b0;
    chk_reset_state("reset");

    // Test 1: full frame k[7:0], pixSof on beat 0.
    for (int k = 0; k < NI; k++) begin
      p = 8'(k);
      set_exp(k, p);
      step(1, p, k == 0, 0);
      if (k == NI - 2) begin
        chk("t1 NNvalid before last", 32'(bus.NNvalid), 32'd0);
        chk("t1 pixCount before last", 32'(bus.pixCount), 32'd783);
      end
    end
    chk("t1 NNvalid", 32'(bus.NNvalid), 32'd1);
    chk("t1 pixReady", 32'(bus.pixReady), 32'd0);
    chk("t1 pixCount", 32'(bus.pixCount), 32'd784);
    chk("t1 frameCount", 32'(bus.frameCount), 32'd1);
    foreach (tbl[i])
      chk($sformatf("t1 elem[%0d]", tbl[i].k), 32'(bus.NNin[(NI-1-tbl[i].k)*DW +: DW]), 32'(tbl[i].elem));
    chk_frame("t1 frame");

    // Test 2: HOLD ignores beats; NNoutValid releases.
    for (int c = 0; c < 20; c++) begin
      step(1, 8'hAA, 1, 0);
      chk("t2 pixReady hold", 32'(bus.pixReady), 32'd0);
      chk("t2 frameErr hold", 32'(bus.frameErr), 32'd0);
    end
    chk_frame("t2 frame frozen");
    chk("t2 pixCount hold", 32'(bus.pixCount), 32'd784);
    step(0, 8'h00, 0, 1);
    chk("t2 NNvalid release", 32'(bus.NNvalid), 32'd0);
    chk("t2 pixReady release", 32'(bus.pixReady), 32'd1);
    chk("t2 pixCount release", 32'(bus.pixCount), 32'd0);
    chk_frame("t2 frame retained");

    // Test 3: early pixSof after 100 pixels restarts the frame.
    for (int k = 0; k < 100; k++) begin
      p = 8'(k * 3);
      set_exp(k, p);
      step(1, p, k == 0, 0);
    end
    chk("t3 pixCount 100", 32'(bus.pixCount), 32'd100);
    set_exp(0, 8'hFE);
    step(1, 8'hFE, 1, 0);
    chk("t3 frameErr pulse", 32'(bus.frameErr), 32'd1);
    chk("t3 pixCount restart", 32'(bus.pixCount), 32'd1);
    chk("t3 MSB elem", 32'(bus.NNin[(NI-1)*DW +: DW]), 32'h7F);
    for (int k = 1; k < NI; k++) begin
      p = 8'(k + 7);
      set_exp(k, p);
      step(1, p, 0, 0);
      if (k == 1) begin
        chk("t3 frameErr cleared", 32'(bus.frameErr), 32'd0);
        chk("t3 pixCount 2", 32'(bus.pixCount), 32'd2);
      end
    end
    chk("t3 NNvalid", 32'(bus.NNvalid), 32'd1);
    chk("t3 frameCount", 32'(bus.frameCount), 32'd2);
    chk_frame("t3 frame");
    step(0, 8'h00, 0, 1);

    // Test 4: random gaps, with NNoutValid pulsed in FILL (must be ignored).
    for (int k = 0; k < NI; k++) begin
      while ($urandom_range(0, 1) == 1) step(0, 8'h5A, 1, 1);
      p = 8'(k * 5 + 1);
      set_exp(k, p);
      step(1, p, k == 0, 0);
    end
    chk("t4 NNvalid", 32'(bus.NNvalid), 32'd1);
    chk("t4 frameCount", 32'(bus.frameCount), 32'd3);
    chk_frame("t4 frame");
    step(0, 8'h00, 0, 1);

    // Restart on the last-pixel position: restart wins, no HOLD.
    for (int k = 0; k < NI - 1; k++) step(1, 8'(k), k == 0, 0);
    step(1, 8'h10, 1, 0);
    chk("last restart frameErr", 32'(bus.frameErr), 32'd1);
    chk("last restart NNvalid", 32'(bus.NNvalid), 32'd0);
    chk("last restart pixCount", 32'(bus.pixCount), 32'd1);
    chk("last restart frameCount", 32'(bus.frameCount), 32'd3);

    // Test 5: reset at pixCount=400 and during HOLD.
    for (int k = 1; k < 400; k++) step(1, 8'(k), 0, 0);
    chk("t5 pixCount 400", 32'(bus.pixCount), 32'd400);
    reset = 1'b1;
    step(1, 8'h33, 0, 0);
    reset = 1'b0;
    chk_reset_state("t5 mid-frame");
    for (int k = 0; k < NI; k++) step(1, 8'(k), k == 0, 0);
    chk("t5 NNvalid before reset", 32'(bus.NNvalid), 32'd1);
    reset = 1'b1;
    step(0, 8'h00, 0, 0);
    reset = 1'b0;
    chk_reset_state("t5 hold");

    // Test 6: back-to-back frames; NNoutValid on the FILL->HOLD edge is ignored.
    for (int k = 0; k < NI; k++) step(1, 8'(k + 1), k == 0, k == NI - 1);
    chk("t6 hold survives same-edge release", 32'(bus.NNvalid), 32'd1);
    for (int c = 0; c < 4; c++) step(0, 8'h00, 0, 0);
    step(0, 8'h00, 0, 1);
    chk("t6 release A", 32'(bus.NNvalid), 32'd0);
    for (int k = 0; k < NI; k++) begin
      p = 8'(255 - k);
      set_exp(k, p);
      step(1, p, k == 0, 0);
    end
    for (int c = 0; c < 4; c++) step(0, 8'h00, 0, 0);
    chk("t6 NNvalid B", 32'(bus.NNvalid), 32'd1);
    chk("t6 frameCount", 32'(bus.frameCount), 32'd2);
    chk_frame("t6 frame B");
    step(0, 8'h00, 0, 1);
    chk("t6 release B", 32'(bus.pixReady), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
